// File: rtl/pixel_colorizer.sv
// Colour stage between the pixel generator and the VGA DAC: mask/breathe colouring
// with frame-synchronous mode latching and a single registered output stage.

module pixel_colorizer_lane #(
  parameter int COLOR_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lit,
  input  logic               en,
  input  logic [COLOR_W-1:0] intensity,
  output logic [COLOR_W-1:0] c
);
  always_ff @(posedge clk) begin
    if (reset)           c <= '0;
    else if (lit && en)  c <= intensity;
    else                 c <= '0;
  end
endmodule

module pixel_colorizer #(
  parameter int COLOR_W  = 3,
  parameter int STEP_DIV = 1
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               frame_start,
  input  logic               display_area,
  input  logic               pixel_on,
  input  logic [3:0]         mode,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B,
  output logic [COLOR_W-1:0] level
);
  localparam int                 NUM_CH = 3;
  localparam int                 CNT_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0]   LAST   = CNT_W'(STEP_DIV - 1);
  localparam logic [COLOR_W-1:0] MAX    = '1;
  localparam logic [COLOR_W-1:0] ONE    = COLOR_W'(1);

  logic [3:0]         mode_q;
  logic [CNT_W-1:0]   tick_cnt;
  logic               dir, dir_nxt, step;
  logic [COLOR_W-1:0] level_nxt, intensity;
  logic [NUM_CH-1:0]  en;
  logic [NUM_CH-1:0][COLOR_W-1:0] rgb;

  assign step = tick && (tick_cnt == LAST);

  // Triangle ramp: turn around at the peaks without repeating MAX or 0
  always_comb begin
    level_nxt = level;
    dir_nxt   = dir;
    if (step) begin
      if (dir) begin
        if (level == MAX) begin dir_nxt = 1'b0; level_nxt = MAX - ONE; end
        else              level_nxt = level + ONE;
      end else begin
        if (level == '0)  begin dir_nxt = 1'b1; level_nxt = ONE; end
        else              level_nxt = level - ONE;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      mode_q   <= '0;
      tick_cnt <= '0;
      level    <= '0;
      dir      <= 1'b1;
    end else begin
      if (frame_start) mode_q <= mode;
      if (step)        tick_cnt <= '0;
      else if (tick)   tick_cnt <= tick_cnt + CNT_W'(1);
      level <= level_nxt;
      dir   <= dir_nxt;
    end
  end

  // Lane 2 = R, 1 = G, 0 = B, matching mode bit order; mask 000 means white
  assign intensity = mode_q[3] ? level : MAX;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign en[i] = (mode_q[2:0] == 3'b000) || mode_q[i];
    pixel_colorizer_lane #(.COLOR_W(COLOR_W)) u_lane (
      .clk       (vga_clk),
      .reset     (reset),
      .lit       (display_area && pixel_on),
      .en        (en[i]),
      .intensity (intensity),
      .c         (rgb[i])
    );
  end

  assign R = rgb[2];
  assign G = rgb[1];
  assign B = rgb[0];
endmodule

// File: tb/tb_pixel_colorizer.sv
// Directed + randomized bench for pixel_colorizer; two instances (STEP_DIV 1 and 3)
// share stimulus and are checked every cycle against a step-count triangle model.

module tb_pixel_colorizer;
  localparam int MAXV = 7;

  logic       vga_clk = 1'b0;
  logic       reset = 1'b0, tick = 1'b0, frame_start = 1'b0;
  logic       display_area = 1'b0, pixel_on = 1'b0;
  logic [3:0] mode = 4'h0;
  logic [2:0] r1, g1, b1, l1, r3, g3, b3, l3;

  int n_pass = 0, n_total = 0;
  int ticks = 0;         // ticks since last reset
  logic [3:0] mq = 4'h0; // modelled latched mode

  always #5 vga_clk = ~vga_clk;

  pixel_colorizer #(.COLOR_W(3), .STEP_DIV(1)) dut1 (
    .vga_clk(vga_clk), .reset(reset), .tick(tick), .frame_start(frame_start),
    .display_area(display_area), .pixel_on(pixel_on), .mode(mode),
    .R(r1), .G(g1), .B(b1), .level(l1));

  pixel_colorizer #(.COLOR_W(3), .STEP_DIV(3)) dut3 (
    .vga_clk(vga_clk), .reset(reset), .tick(tick), .frame_start(frame_start),
    .display_area(display_area), .pixel_on(pixel_on), .mode(mode),
    .R(r3), .G(g3), .B(b3), .level(l3));

  // Level after n steps of a 0..MAX..0 triangle with period 2*MAX
  function automatic int tri_lvl(input int n);
    int p;
    p = n % (2 * MAXV);
    return (p <= MAXV) ? p : 2 * MAXV - p;
  endfunction

  function automatic int chan(input int idx, input logic [3:0] m, input int lv, input bit lit);
    if (!lit) return 0;
    if (m[2:0] == 3'b000 || m[idx]) return m[3] ? lv : MAXV;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock: drive inputs, predict from pre-edge model state, advance model, compare
  task automatic cyc(input bit rs, input bit tk, input bit fs, input bit da,
                     input bit po, input logic [3:0] md);
    int er1, eg1, eb1, er3, eg3, eb3;
    bit lit;
    reset = rs; tick = tk; frame_start = fs; display_area = da; pixel_on = po; mode = md;
    lit = da && po;
    er1 = rs ? 0 : chan(2, mq, tri_lvl(ticks), lit);
    eg1 = rs ? 0 : chan(1, mq, tri_lvl(ticks), lit);
    eb1 = rs ? 0 : chan(0, mq, tri_lvl(ticks), lit);
    er3 = rs ? 0 : chan(2, mq, tri_lvl(ticks / 3), lit);
    eg3 = rs ? 0 : chan(1, mq, tri_lvl(ticks / 3), lit);
    eb3 = rs ? 0 : chan(0, mq, tri_lvl(ticks / 3), lit);
    if (rs) begin ticks = 0; mq = 4'h0; end
    else begin
      if (tk) ticks++;
      if (fs) mq = md;
    end
    @(posedge vga_clk); #1;
    chk("R1", 8'(r1), 8'(er1));
    chk("G1", 8'(g1), 8'(eg1));
    chk("B1", 8'(b1), 8'(eb1));
    chk("level1", 8'(l1), 8'(tri_lvl(ticks)));
    chk("R3", 8'(r3), 8'(er3));
    chk("G3", 8'(g3), 8'(eg3));
    chk("B3", 8'(b3), 8'(eb3));
    chk("level3", 8'(l3), 8'(tri_lvl(ticks / 3)));
  endtask

  initial begin
    // Reset with a lit in-area pixel, then release without frame_start: white
    cyc(1, 0, 0, 1, 1, 4'h0);
    cyc(1, 0, 0, 1, 1, 4'h0);
    chk("rst_black", 8'({r1, g1, b1}), 8'h00);
    cyc(0, 0, 0, 1, 1, 4'h0);
    cyc(0, 0, 0, 1, 1, 4'h0);
    chk("post_rst_white", 8'({r1, g1, b1}), 8'hff);

    // Every mask; lit, unlit and out-of-area pixels
    for (int m = 0; m < 8; m++) begin
      cyc(0, 0, 1, 0, 0, 4'(m));
      cyc(0, 0, 0, 1, 1, 4'(m));
      cyc(0, 0, 0, 1, 0, 4'(m));
      cyc(0, 0, 0, 0, 1, 4'(m));
    end

    // Frame-synchronous latch: mid-frame mode change ignored until frame_start
    cyc(0, 0, 1, 0, 0, 4'b0100);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 4'b0010);
    chk("latch_hold_R", 8'(r1), 8'd7);
    cyc(0, 0, 1, 1, 1, 4'b0010);
    chk("latch_edge_R", 8'(r1), 8'd7);
    cyc(0, 0, 0, 1, 1, 4'b0010);
    chk("latch_new_G", 8'({r1, g1}), 8'h07);

    // Breathe ramp on blue, ticks every 5 cycles; slow instance divides by 3
    cyc(1, 0, 0, 0, 0, 4'h0);
    cyc(0, 0, 1, 0, 0, 4'b1001);
    for (int t = 0; t < 16; t++) begin
      cyc(0, 1, 0, 1, 1, 4'b1001);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 4'b1001);
    end
    chk("ramp_end", 8'(l1), 8'd2);

    // Divider: 7 ticks -> level 2; two more complete the third step
    cyc(1, 0, 0, 0, 0, 4'h0);
    for (int t = 0; t < 7; t++) begin
      cyc(0, 1, 0, 0, 0, 4'h0);
      cyc(0, 0, 0, 0, 0, 4'h0);
    end
    chk("div7", 8'(l3), 8'd2);
    cyc(0, 1, 0, 0, 0, 4'h0);
    chk("div8", 8'(l3), 8'd2);
    cyc(0, 1, 0, 0, 0, 4'h0);
    chk("div9", 8'(l3), 8'd3);

    // Simultaneous tick + frame_start + pixel: old mode/level, then new
    cyc(1, 0, 0, 0, 0, 4'h0);
    cyc(0, 1, 1, 1, 1, 4'b1111);
    chk("simul_old", 8'({r1, g1, b1}), 8'hff);
    cyc(0, 0, 0, 1, 1, 4'b0000);
    chk("simul_new", 8'({r1, g1, b1}), 8'b01_001_001);

    // Randomized traffic including mid-frame resets
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pixel_colorizer.md
# pixel_colorizer

Parametrised colour stage between the character/pixel generator and the VGA DAC pins. Converts a 1-bit per-pixel "lit" stream plus a 4-bit mode into R/G/B words of configurable depth. Supports seven colour masks, an animated "breathe" intensity (triangle ramp stepped by a slow tick), and frame-synchronous mode latching to prevent mid-frame tearing. Output is registered with a fixed one-cycle latency, and is forced black outside the display area.

## Interface
- COLOR_W, 3, bits per colour channel; MAX = 2^COLOR_W − 1; legal values 1..8.
- STEP_DIV, 1, number of `tick` strobes per breathe step; must be ≥ 1.

- vga_clk  in  1  pixel clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle strobe from the slow timebase, e.g. 10 Hz.
- frame_start  in  1  one-cycle strobe once per frame, during blanking.
- display_area  in  1  high while the beam is inside the visible region.
- pixel_on  in  1  serial pixel bit from the character generator; 1 = lit.
- mode  in  4  colour request. Bits [2:0] = {R,G,B} enable mask; 000 means white. Bit [3] = breathe enable.
- R, G, B  out  COLOR_W each  registered colour outputs.
- level  out  COLOR_W  current breathe level, for debug and LEDs.

## Operation
- **mode_q (4 bits)**
  - Loaded from `mode` on any cycle with `frame_start` = 1.
  - Holds otherwise; the `mode` input is ignored mid-frame.
  - Reset value is 0 (white, steady).
- **Step divider (tick_cnt)**
  - Each `tick` increments tick_cnt.
  - When tick_cnt = STEP_DIV−1 and `tick` = 1: issue one step and clear tick_cnt.
  - With STEP_DIV = 1, every tick is a step.
- **Breathe state: level (COLOR_W bits) and dir (1 = up)**
  - Free-running, independent of mode.
  - On a step with dir = 1: if level = MAX, set dir = 0 and level = MAX−1; otherwise level + 1.
  - On a step with dir = 0: if level = 0, set dir = 1 and level = 1; otherwise level − 1.
  - Resulting sequence is 0,1,…,MAX,MAX−1,…,0,1,… with period 2·MAX steps; no repeated values at the peaks.
  - COLOR_W = 1 degenerates to 0,1,0,1.
- **Intensity I** = mode_q[3] ? level : MAX.
- **Channel value**, per channel c ∈ {R,G,B}:
  - If display_area & pixel_on: c = I when mask bit c = 1 or mask = 000; otherwise 0.
  - Else: c = 0.
- **Mask decoding:** 100 red, 010 green, 001 blue, 110 yellow, 011 cyan, 101 magenta, 111 white, 000 white.
- **Reset (synchronous)** sets R = G = B = 0, level = 0, dir = 1, tick_cnt = 0, mode_q = 0.
  - Reset dominates tick and frame_start in the same cycle.

## Timing
- **Latency:** outputs at edge k+1 reflect display_area/pixel_on sampled at edge k. Exactly one register stage; the caller delays hsync/vsync by one cycle to match.
- **Output computation:** uses mode_q and level as held before edge k, i.e. pre-update values.
  - A mode latched at edge k affects outputs from edge k+1 onward.
  - A level step at edge k appears on R/G/B from edge k+1 onward.
- **Simultaneous tick and frame_start:** both take effect at the same edge, independently.
- **`level` port:** equals the level register, with no extra delay.
- **Reset deassertion:** the first cycle with reset = 0 processes inputs normally. Outputs are black until one cycle after the first lit, in-area pixel.
- **Reset mid-frame:** outputs go black at the next edge and mode reverts to white until the next frame_start.
- **tick held high for N cycles:** counts as N ticks; no edge detection. The caller guarantees one-cycle strobes.

## Test plan
1. **Reset/default.** Assert reset for 2 cycles with display_area = pixel_on = 1. Then release with no frame_start. Required: R=G=B=0 during reset; R=G=B=7 from the 2nd cycle after release; level = 0.
2. **Mask decoding.** For each mode 4'b0000–4'b0111: latch via frame_start, then drive pixel_on = 1. Required per the decode list; e.g. 0110 → R=7, G=7, B=0; 0101 → R=7, G=0, B=7. With pixel_on = 0 or display_area = 0: all channels 0.
3. **Frame-synchronous latch.** Latch mode = 0100, then change `mode` to 0010 mid-frame with no frame_start. Required: output stays R=7, G=0 until the cycle after the next frame_start, then switches to G=7, R=0.
4. **Breathe ramp.** mode = 1001, COLOR_W = 3, STEP_DIV = 1. Apply 16 ticks spaced 5 cycles apart. Required: level and B follow 1,2,3,4,5,6,7,6,5,4,3,2,1,0,1,2; R = G = 0.
5. **Divider.** STEP_DIV = 3. Apply 7 ticks. Required: level steps only on the 3rd and 6th tick, ending at level = 2, tick_cnt = 1.
6. **Simultaneous events and latency.** Drive tick, frame_start (mode 1111), and a single-cycle pixel_on pulse all on the same edge k. Required: the pixel appears at edge k+1 using the old mode_q/level. The next lit pixel shows R = G = B = new level (1).
